// File: rtl/ariane_pkg.sv
// Shared core types used by the commit queue and its neighbours.
// riscv     : architectural widths.
// ariane_pkg: transaction-id width, commit queue depth, exception and
//             scoreboard entry types.
package riscv;
    localparam int XLEN = 64;
endpackage

package ariane_pkg;
    localparam int TRANS_ID_BITS       = 3;
    // Shared by issue and commit so both sides agree on the queue depth.
    localparam int NR_COMMIT_Q_ENTRIES = 8;

    typedef struct packed {
        logic [riscv::XLEN-1:0] cause;
        logic [riscv::XLEN-1:0] tval;
        logic                   valid;
    } exception_t;

    typedef enum logic [2:0] {
        NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
    } fu_t;

    typedef struct packed {
        logic [riscv::XLEN-1:0]   pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [riscv::XLEN-1:0]   result;
        logic                     valid;   // written back
        exception_t               ex;
    } scoreboard_entry_t;
endpackage

// File: rtl/commit_queue.sv
// In-order retire buffer. Allocates a slot per issued instruction, captures
// write-back results/exceptions by transaction id, presents the oldest
// NR_COMMIT_PORTS entries to commit and pops them on acknowledge.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              discard all entries (overrides everything else)
//   issue_valid_i/_instr_i, issue_ready_o, issue_trans_id_o  allocation side
//   wb_valid_i/_trans_id_i/_data_i/_ex_i                     write-back ports
//   commit_instr_o, commit_ack_i                             commit side
//   empty_o              no slot occupied
module commit_queue
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = NR_COMMIT_Q_ENTRIES,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_WB_PORTS     = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    input  logic                                          issue_valid_i,
    input  scoreboard_entry_t                             issue_instr_i,
    output logic                                          issue_ready_o,
    output logic [TRANS_ID_BITS-1:0]                      issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                        wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]     wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][riscv::XLEN-1:0]       wb_data_i,
    input  exception_t [NR_WB_PORTS-1:0]                  wb_ex_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]       commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]                    commit_ack_i,
    output logic                                          empty_o
);
    localparam int unsigned PTR_W = $clog2(NR_ENTRIES);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Control state (reset) and payload (not reset; masked by r_occ/r_count).
    logic [NR_ENTRIES-1:0] r_occ;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    scoreboard_entry_t     r_slot [NR_ENTRIES];

    logic                                    w_issue;
    logic [NR_COMMIT_PORTS-1:0]              w_pop;
    logic [CNT_W-1:0]                        w_pop_cnt;
    logic [NR_COMMIT_PORTS-1:0][PTR_W-1:0]   w_rd_idx;
    logic [NR_WB_PORTS-1:0][PTR_W-1:0]       w_wb_idx;

    // Ready is based on the registered count only, so a same-cycle pop never
    // makes room for an issue; the tail slot is therefore never being popped.
    assign issue_ready_o    = (r_count != CNT_W'(NR_ENTRIES));
    assign issue_trans_id_o = TRANS_ID_BITS'(r_tail);
    assign empty_o          = (r_count == '0);
    assign w_issue          = issue_valid_i & issue_ready_o & ~flush_i;

    // Depth is a power of two no larger than the id space, so the low id bits
    // address the slot directly.
    always_comb begin
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            w_wb_idx[p] = wb_trans_id_i[p][PTR_W-1:0];
        end
    end

    // Present the oldest entries. Ports beyond the live count show all-zero,
    // which also keeps unreset payload off the outputs after reset.
    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_rd_idx[i]       = r_head + PTR_W'(i);
            commit_instr_o[i] = '0;
            if (CNT_W'(i) < r_count) begin
                commit_instr_o[i]       = r_slot[w_rd_idx[i]];
                commit_instr_o[i].valid = r_occ[w_rd_idx[i]] & r_slot[w_rd_idx[i]].valid;
            end
        end
    end

    // Retire strictly in order: a port pops only if every older port pops too,
    // and an ack on a not-yet-ready entry is dropped.
    always_comb begin : pop_chain
        logic v_chain;
        v_chain   = 1'b1;
        w_pop     = '0;
        w_pop_cnt = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_pop[i]  = commit_ack_i[i] & commit_instr_o[i].valid & v_chain;
            v_chain   = w_pop[i];
            w_pop_cnt = w_pop_cnt + CNT_W'(w_pop[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_occ   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_occ   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_issue) begin
                r_occ[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (w_pop[i]) r_occ[w_rd_idx[i]] <= 1'b0;
            end
            r_head  <= r_head + PTR_W'(w_pop_cnt);
            r_count <= r_count + CNT_W'(w_issue) - w_pop_cnt;
        end
    end

    // Payload. Write-back checks the registered occupied bit, so a write-back
    // aimed at the slot being issued this cycle is dropped. Later ports are
    // written last and win on a (disallowed) collision.
    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_slot[r_tail]          <= issue_instr_i;
            r_slot[r_tail].valid    <= 1'b0;
            r_slot[r_tail].trans_id <= TRANS_ID_BITS'(r_tail);
        end
        if (!flush_i) begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && r_occ[w_wb_idx[p]]) begin
                    r_slot[w_wb_idx[p]].result <= wb_data_i[p];
                    r_slot[w_wb_idx[p]].valid  <= 1'b1;
                    if (wb_ex_i[p].valid) r_slot[w_wb_idx[p]].ex <= wb_ex_i[p];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                for (int q = p + 1; q < NR_WB_PORTS; q++) begin
                    assert (!(wb_valid_i[p] && wb_valid_i[q] &&
                              wb_trans_id_i[p] == wb_trans_id_i[q]))
                    else $error("commit_queue: write-back ports %0d and %0d target one slot", p, q);
                end
            end
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                assert (!(commit_ack_i[i] && !commit_instr_o[i].valid))
                else $warning("commit_queue: ack on port %0d with no ready entry, ignored", i);
            end
        end
    end

    if (NR_COMMIT_PORTS > 1) begin : g_ack_order
        always @(posedge clk_i) begin
            if (rst_ni && !flush_i) begin
                assert (!(commit_ack_i[1] && !commit_ack_i[0]))
                else $warning("commit_queue: ack on port 1 without port 0, ignored");
            end
        end
    end
`endif

endmodule
